// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: synchronises and debounces supply_ok_async,
// releases NUM_CHAN domain resets in order with a fixed gap between them,
// then raises porb. A brown-out or a software request trips every reset at once.
//
// state   | meaning
// HOLD    | supply not yet qualified; all resets asserted, on-filter counting
// RELEASE | channels being released one per STAGE_CYCLES; brown-out armed
// RUN     | all channels released, porb=1; brown-out armed
module por_reset_sequencer #(
    parameter int NUM_CHAN     = 4,
    parameter int CNT_W        = 16,
    parameter int ON_CYCLES    = 500,
    parameter int OFF_CYCLES   = 4,
    parameter int STAGE_CYCLES = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                supply_ok_async,
    input  logic                sw_rst_req,
    output logic [NUM_CHAN-1:0] rst_n_out,
    output logic                porb,
    output logic                por,
    output logic                brownout_evt,
    output logic [1:0]          state_o
);

    localparam int IDX_W = $clog2(NUM_CHAN + 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(NUM_CHAN);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;

    state_t                 state_q, state_nx;
    logic [CNT_W-1:0]       cnt_q, cnt_nx;
    logic [CNT_W-1:0]       off_q, off_nx;
    logic [IDX_W-1:0]       idx_q, idx_nx;
    logic [NUM_CHAN-1:0]    rst_q, rst_nx;
    logic                   porb_q, porb_nx;
    logic                   por_q;
    logic                   bo_q, bo_nx;
    logic                   bo_trip;

    assign sync = sync_ff[SYNC_STAGES-1];

    // Metastability chain on the raw supply-good level
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], supply_ok_async};
        end
    end

    // State, counters and all outputs are registered here
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            porb_q  <= 1'b0;
            por_q   <= 1'b1;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            off_q   <= off_nx;
            idx_q   <= idx_nx;
            rst_q   <= rst_nx;
            porb_q  <= porb_nx;
            por_q   <= ~porb_nx;
            bo_q    <= bo_nx;
        end
    end

    // Next-state: on-filter in HOLD, staged release, trip handling
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        off_nx   = off_q;
        idx_nx   = idx_q;
        rst_nx   = rst_q;
        porb_nx  = porb_q;
        bo_nx    = 1'b0;
        bo_trip  = 1'b0;

        case (state_q)
            ST_HOLD: begin
                rst_nx  = '0;
                porb_nx = 1'b0;
                off_nx  = '0;
                idx_nx  = '0;
                // Any low sample or a software request restarts the whole window
                if (sw_rst_req || !sync) begin
                    cnt_nx = '0;
                end else if (cnt_q == ON_LAST) begin
                    state_nx  = ST_RELEASE;
                    rst_nx[0] = 1'b1;
                    idx_nx    = IDX_W'(1);
                    cnt_nx    = '0;
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end

            ST_RELEASE, ST_RUN: begin
                off_nx  = sync ? '0 : off_q + 1'b1;
                bo_trip = !sync && (off_q == OFF_LAST);
                // Brown-out wins the event flag even when software asks too
                if (bo_trip || sw_rst_req) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = '0;
                    off_nx   = '0;
                    idx_nx   = '0;
                    rst_nx   = '0;
                    porb_nx  = 1'b0;
                    bo_nx    = bo_trip;
                end else if (state_q == ST_RELEASE) begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_nx = '0;
                        if (idx_q < IDX_END) begin
                            for (int i = 0; i < NUM_CHAN; i++) begin
                                if (idx_q == IDX_W'(i)) rst_nx[i] = 1'b1;
                            end
                            idx_nx = idx_q + 1'b1;
                        end else begin
                            state_nx = ST_RUN;
                            porb_nx  = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_nx = ST_HOLD;
                cnt_nx   = '0;
                off_nx   = '0;
                idx_nx   = '0;
                rst_nx   = '0;
                porb_nx  = 1'b0;
            end
        endcase
    end

    assign rst_n_out    = rst_q;
    assign porb         = porb_q;
    assign por          = por_q;
    assign brownout_evt = bo_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Bench for por_reset_sequencer: an elapsed-time model of the release
// schedule checked every cycle, plus hand-computed edge-by-edge points.
module tb_por_reset_sequencer;

    localparam int NC  = 3;
    localparam int ON  = 8;
    localparam int OFF = 3;
    localparam int STG = 4;
    localparam int SY  = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          supply = 1'b0;
    logic          sw = 1'b0;
    logic [NC-1:0] rst_n_out;
    logic          porb;
    logic          por;
    logic          bo;
    logic [1:0]    state_o;

    por_reset_sequencer #(
        .NUM_CHAN(NC), .CNT_W(16), .ON_CYCLES(ON), .OFF_CYCLES(OFF),
        .STAGE_CYCLES(STG), .SYNC_STAGES(SY)
    ) dut (
        .clk(clk), .resetn(resetn), .supply_ok_async(supply), .sw_rst_req(sw),
        .rst_n_out(rst_n_out), .porb(porb), .por(por),
        .brownout_evt(bo), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Model: supply delay line, run lengths, and the edge at which channel 0 went
    bit            sh [SY];
    bit            active = 1'b0;
    bit            model_valid = 1'b0;
    int            hi_run = 0;
    int            lo_run = 0;
    int            t0 = 0;
    logic [NC-1:0] e_rst = '0;
    bit            e_porb = 1'b0;
    bit            e_bo = 1'b0;
    logic [1:0]    e_state = 2'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Model step on each rising edge
    always @(posedge clk) begin : model_step
        bit s;
        int el;
        edge_n++;
        s    = sh[SY-1];
        e_bo = 1'b0;
        if (!resetn) begin
            for (int i = 0; i < SY; i++) sh[i] = 1'b0;
            active      = 1'b0;
            hi_run      = 0;
            lo_run      = 0;
            model_valid = 1'b1;
        end else begin
            for (int i = SY - 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = supply;
            if (!active) begin
                if (sw || !s) begin
                    hi_run = 0;
                end else begin
                    hi_run++;
                    if (hi_run == ON) begin
                        active = 1'b1;
                        t0     = edge_n;
                        lo_run = 0;
                        hi_run = 0;
                    end
                end
            end else begin
                lo_run = s ? 0 : lo_run + 1;
                if (lo_run == OFF || sw) begin
                    e_bo   = (lo_run == OFF);
                    active = 1'b0;
                    hi_run = 0;
                    lo_run = 0;
                end
            end
        end
        if (active) begin
            el = edge_n - t0;
            for (int k = 0; k < NC; k++) e_rst[k] = (el >= k * STG);
            e_porb  = (el >= NC * STG);
            e_state = e_porb ? 2'd2 : 2'd1;
        end else begin
            e_rst   = '0;
            e_porb  = 1'b0;
            e_state = 2'd0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            chk("rst_n_out", 32'(rst_n_out), 32'(e_rst));
            chk("porb", 32'(porb), 32'(e_porb));
            chk("por", 32'(por), 32'(!e_porb));
            chk("brownout_evt", 32'(bo), 32'(e_bo));
            chk("state_o", 32'(state_o), 32'(e_state));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        edges(3);
        chk("reset rst", 32'(rst_n_out), 32'h0);
        chk("reset por", 32'(por), 32'h1);
        resetn = 1'b1;
        edges(2);

        // Clean power-up; supply rises before E1
        supply = 1'b1;
        edges(9);
        chk("t1 E9 rst", 32'(rst_n_out), 32'h0);
        chk("t1 E9 state", 32'(state_o), 32'h0);
        edges(1);
        chk("t1 E10 rst", 32'(rst_n_out), 32'h1);
        chk("t1 E10 state", 32'(state_o), 32'h1);
        edges(4);
        chk("t1 E14 rst", 32'(rst_n_out), 32'h3);
        edges(4);
        chk("t1 E18 rst", 32'(rst_n_out), 32'h7);
        edges(3);
        chk("t1 E21 porb", 32'(porb), 32'h0);
        edges(1);
        chk("t1 E22 porb", 32'(porb), 32'h1);
        chk("t1 E22 por", 32'(por), 32'h0);
        chk("t1 E22 state", 32'(state_o), 32'h2);

        // Short low in RUN is ignored
        supply = 1'b0;
        edges(2);
        supply = 1'b1;
        edges(6);
        chk("t3 short rst", 32'(rst_n_out), 32'h7);
        chk("t3 short state", 32'(state_o), 32'h2);

        // Three-cycle low trips on the third synced-low edge (E5)
        supply = 1'b0;
        edges(3);
        supply = 1'b1;
        edges(1);
        chk("t3 E4 rst", 32'(rst_n_out), 32'h7);
        chk("t3 E4 bo", 32'(bo), 32'h0);
        edges(1);
        chk("t3 E5 rst", 32'(rst_n_out), 32'h0);
        chk("t3 E5 bo", 32'(bo), 32'h1);
        chk("t3 E5 por", 32'(por), 32'h1);
        chk("t3 E5 state", 32'(state_o), 32'h0);
        edges(1);
        chk("t3 E6 bo", 32'(bo), 32'h0);
        edges(7);
        chk("t3 E13 rst", 32'(rst_n_out), 32'h1);
        edges(12);
        chk("t3 E25 porb", 32'(porb), 32'h1);

        // Software request in RUN
        sw = 1'b1;
        edges(1);
        sw = 1'b0;
        chk("t4 E1 rst", 32'(rst_n_out), 32'h0);
        chk("t4 E1 bo", 32'(bo), 32'h0);
        chk("t4 E1 state", 32'(state_o), 32'h0);
        edges(7);
        chk("t4 E8 rst", 32'(rst_n_out), 32'h0);
        edges(1);
        chk("t4 E9 rst", 32'(rst_n_out), 32'h1);
        edges(11);
        chk("t4 E20 porb", 32'(porb), 32'h0);
        edges(1);
        chk("t4 E21 porb", 32'(porb), 32'h1);

        // Software request in HOLD restarts the on-filter
        sw = 1'b1;
        edges(1);
        sw = 1'b0;
        edges(5);
        sw = 1'b1;
        edges(1);
        sw = 1'b0;
        edges(2);
        chk("t4h E9 state", 32'(state_o), 32'h0);
        edges(5);
        chk("t4h E14 state", 32'(state_o), 32'h0);
        edges(1);
        chk("t4h E15 state", 32'(state_o), 32'h1);
        chk("t4h E15 rst", 32'(rst_n_out), 32'h1);

        // Brown-out and software request on the same edge in RELEASE
        supply = 1'b0;
        edges(4);
        chk("t5 E4 state", 32'(state_o), 32'h1);
        sw = 1'b1;
        edges(1);
        sw = 1'b0;
        chk("t5 E5 bo", 32'(bo), 32'h1);
        chk("t5 E5 rst", 32'(rst_n_out), 32'h0);
        chk("t5 E5 state", 32'(state_o), 32'h0);
        edges(1);
        chk("t5 E6 bo", 32'(bo), 32'h0);
        supply = 1'b1;

        // resetn pulse in RELEASE with idx=2
        edges(10);
        chk("t6 E16 rst", 32'(rst_n_out), 32'h1);
        edges(5);
        chk("t6 E21 rst", 32'(rst_n_out), 32'h3);
        resetn = 1'b0;
        edges(1);
        resetn = 1'b1;
        chk("t6 E22 rst", 32'(rst_n_out), 32'h0);
        chk("t6 E22 state", 32'(state_o), 32'h0);
        chk("t6 E22 por", 32'(por), 32'h1);
        chk("t6 E22 bo", 32'(bo), 32'h0);
        edges(10);
        chk("t6 E32 rst", 32'(rst_n_out), 32'h1);
        edges(12);
        chk("t6 E44 porb", 32'(porb), 32'h1);

        // Glitch in HOLD: 7 highs, 1 low, then high
        resetn = 1'b0;
        supply = 1'b0;
        edges(2);
        resetn = 1'b1;
        edges(3);
        supply = 1'b1;
        edges(7);
        supply = 1'b0;
        edges(1);
        supply = 1'b1;
        edges(2);
        chk("t2 E10 state", 32'(state_o), 32'h0);
        edges(7);
        chk("t2 E17 state", 32'(state_o), 32'h0);
        edges(1);
        chk("t2 E18 state", 32'(state_o), 32'h1);
        chk("t2 E18 rst", 32'(rst_n_out), 32'h1);
        edges(12);
        chk("t2 E30 porb", 32'(porb), 32'h1);
        edges(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
